// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types and default sizing for the audio sample FIFO
//                (sample type, output FSM state encoding, default depth and
//                prefill level).
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        RD_L = 2'd2,
        RD_R = 2'd3
    } afifo_state_e;

    localparam int AUDIO_FIFO_DEPTH_DEFAULT   = 16;
    localparam int AUDIO_FIFO_PREFILL_DEFAULT = 8;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/audio_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : audio_fifo_ram
//  Description : Simple dual-port sample RAM, one write port and one
//                synchronous read port (data appears one cycle after the
//                address is presented).
//  Ports       : clk        - clock
//                wr_en_i    - write enable
//                wr_addr_i  - write address
//                wr_data_i  - write data (16-bit sample)
//                rd_addr_i  - read address, registered internally
//                rd_data_o  - read data, valid the cycle after rd_addr_i
//  Revision    : 1.0  initial release
// ============================================================================
module audio_fifo_ram
    import audio_pkg::*;
#(
    parameter int DEPTH = AUDIO_FIFO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [15:0]   wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [15:0]   rd_data_o
);

    // Storage carries no reset; occupancy is tracked by the FIFO control.
    sample_t mem_q [DEPTH];
    sample_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule : audio_fifo_ram
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sample_fifo
//  Description : Sink stage for a decoder audio stream. Requests samples with
//                a strobe, buffers them as interleaved L/R in a FIFO, and on
//                each sample_tick delivers one stereo pair to the DAC
//                registers. Playback starts/resumes only after PREFILL
//                samples are buffered.
//  Options     : AUDIO_FIFO_STATS_EN - adds saturating 16-bit overflow and
//                underrun event counters (cleared by reset only).
//  Ports       : clk, reset        - clock, asynchronous active-high reset
//                in_write_i        - sample valid from source
//                in_sample_i       - sample data (L,R,L,R...)
//                in_strobe_o       - 1-cycle request for one more sample
//                sample_tick_i     - output-rate enable
//                left_o / right_o  - signed stereo pair to DAC
//                playing_o         - pairs are being delivered
//                overflow_o        - sticky: write dropped while full
//                underrun_o        - sticky: tick with < 2 samples
//                clear_flags_i     - clears the sticky flags
//                overflow_count_o, underrun_count_o (option only)
//  Revision    : 1.0  initial release
// ============================================================================
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH   = AUDIO_FIFO_DEPTH_DEFAULT,
    parameter int PREFILL = AUDIO_FIFO_PREFILL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_write_i,
    input  logic [15:0] in_sample_i,
    output logic        in_strobe_o,
    input  logic        sample_tick_i,
    input  logic        clear_flags_i,
    output logic [15:0] left_o,
    output logic [15:0] right_o,
    output logic        playing_o,
    output logic        overflow_o,
    output logic        underrun_o
`ifdef AUDIO_FIFO_STATS_EN
    ,
    output logic [15:0] overflow_count_o,
    output logic [15:0] underrun_count_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LVL_ONE     = LW'(1);
    localparam logic [LW-1:0] LVL_TWO     = LW'(2);
    localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW-1:0] PTR_TWO     = AW'(2);

    afifo_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] pending_q, pending_d;
    logic          strobe_q, strobe_d;
    logic          pop_q, pop_d;
    sample_t       left_q, left_d;
    sample_t       right_q, right_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;

    logic          w_full;
    logic          w_wr_accept;
    logic          w_overflow_evt;
    logic          w_underrun_evt;
    logic [LW:0]   w_committed;
    logic [LW-1:0] w_level_avail;
    logic [AW-1:0] w_rd_addr;
    logic [15:0]   w_rd_data;

    assign w_full         = (level_q == LVL_FULL);
    assign w_wr_accept    = in_write_i && !w_full;
    assign w_overflow_evt = in_write_i && w_full;
    // Buffered samples plus samples already requested: never request more
    // than the FIFO can hold.
    assign w_committed    = {1'b0, level_q} + {1'b0, pending_q};
    // During the pop cycle the pair just read is still counted in level_q.
    assign w_level_avail  = pop_q ? (level_q - LVL_TWO) : level_q;

    audio_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (w_wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_sample_i),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_rd_data)
    );

    // RD_L fetches the left sample, RD_R the right one (one-cycle RAM latency).
    assign w_rd_addr = (state_q == RD_R) ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // Output state machine
    always_comb begin
        state_d        = state_q;
        w_underrun_evt = 1'b0;
        case (state_q)
            FILL: begin
                if (level_q >= LVL_PREFILL) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (sample_tick_i) begin
                    if (w_level_avail >= LVL_TWO) begin
                        state_d = RD_L;
                    end else begin
                        w_underrun_evt = 1'b1;
                        state_d        = FILL;
                    end
                end
            end
            RD_L:    state_d = RD_R;
            RD_R:    state_d = IDLE;
            default: state_d = FILL;
        endcase
    end

    // Datapath, credit and flags
    always_comb begin
        pop_d    = (state_q == RD_R);
        left_d   = left_q;
        right_d  = right_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Left lands one cycle before right; a consumer sampling on the next
        // tick always sees a consistent pair.
        if (state_q == RD_R) begin
            left_d = w_rd_data;
        end
        if (pop_q) begin
            right_d  = w_rd_data;
            rd_ptr_d = rd_ptr_q + PTR_TWO;
        end

        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (w_wr_accept) begin
            level_d = level_d + LVL_ONE;
        end
        if (pop_q) begin
            level_d = level_d - LVL_TWO;
        end

        strobe_d = !strobe_q && (w_committed < {1'b0, LVL_FULL});

        case ({strobe_q, in_write_i})
            2'b10:   pending_d = pending_q + LVL_ONE;
            2'b01:   pending_d = (pending_q != '0) ? (pending_q - LVL_ONE) : '0;
            default: pending_d = pending_q;
        endcase

        // Setting has priority over clearing in the same cycle.
        overflow_d = overflow_q;
        if (clear_flags_i) begin
            overflow_d = 1'b0;
        end
        if (w_overflow_evt) begin
            overflow_d = 1'b1;
        end

        underrun_d = underrun_q;
        if (clear_flags_i) begin
            underrun_d = 1'b0;
        end
        if (w_underrun_evt) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pending_q  <= '0;
            strobe_q   <= 1'b0;
            pop_q      <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pending_q  <= pending_d;
            strobe_q   <= strobe_d;
            pop_q      <= pop_d;
            left_q     <= left_d;
            right_q    <= right_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_strobe_o = strobe_q;
    assign left_o      = left_q;
    assign right_o     = right_q;
    assign playing_o   = (state_q != FILL);
    assign overflow_o  = overflow_q;
    assign underrun_o  = underrun_q;

`ifdef AUDIO_FIFO_STATS_EN
    logic [15:0] ovf_cnt_q;
    logic [15:0] unr_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
            unr_cnt_q <= '0;
        end else begin
            if (w_overflow_evt && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
            if (w_underrun_evt && (unr_cnt_q != 16'hFFFF)) begin
                unr_cnt_q <= unr_cnt_q + 16'd1;
            end
        end
    end

    assign overflow_count_o = ovf_cnt_q;
    assign underrun_count_o = unr_cnt_q;
`else
    // Statistics counters not built; only the sticky flags report events.
`endif

endmodule : audio_sample_fifo
`default_nettype wire
